branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Sequences branch/jump resolution in the 32-bit RV32I core and owns the 2-bit branch history table (BHT) that fetch uses for prediction.
- Accepts one control-transfer op at a time over a valid/ready handshake and drives the unsigned-mode select of the shared branch comparator.
- Samples the comparator's equal/less-than flags, computes the actual outcome and target, and issues a one-cycle resolve/redirect pulse.
- Updates the BHT for conditional branches.

Parameters:
- XLEN, 32, datapath and PC width.
- BHT_ENTRIES, 16, BHT depth; power of two, at least 2.
- IDX_W, $clog2(BHT_ENTRIES), BHT index width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  op offered
- req_ready  out  1  block can accept
- req_pc  in  XLEN  PC of the op
- req_imm  in  XLEN  sign-extended offset
- req_rs1  in  XLEN  base for JALR
- req_funct3  in  3  branch condition
- req_is_jal  in  1  JAL op
- req_is_jalr  in  1  JALR op
- req_pred_taken  in  1  prediction fetch used for this op
- flush  in  1  kill in-flight op
- cmp_brUn  out  1  comparator unsigned select
- cmp_brEq  in  1  comparator equal flag
- cmp_brLt  in  1  comparator less-than flag
- pred_pc  in  XLEN  fetch lookup PC
- pred_taken  out  1  BHT prediction for pred_pc (combinational)
- resolve_valid  out  1  one-cycle resolve pulse
- resolve_taken  out  1  actual outcome
- mispredict  out  1  outcome differs from req_pred_taken
- redirect_pc  out  XLEN  correct next PC
- link_pc  out  XLEN  req_pc+4, used for rd on JAL/JALR
- illegal_br  out  1  funct3 was 010 or 011

Behaviour:
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, latch all req_* fields and go to EVAL.
  - EVAL: cmp_brUn = latched funct3[1]. The datapath holds comparator operands stable during this cycle. At the end of EVAL, register the outcome and go to RESOLVE.
  - RESOLVE: resolve_valid=1 for exactly one cycle, BHT written at the end of the cycle, then go to IDLE.
- Latency and throughput: an op accepted at edge T pulses resolve_valid in cycle T+2. req_ready is low during EVAL and RESOLVE, so there is no back-to-back accept. Peak throughput is one op per 3 cycles.
- cmp_brUn is 0 outside EVAL.
- Taken rules:
  - 000 taken if Eq; 001 if !Eq; 100 if Lt; 101 if !Lt; 110 if Lt; 111 if !Lt.
  - 010/011: not taken, and illegal_br=1 in RESOLVE.
  - JAL/JALR: always taken, and the comparator flags are ignored.
  - If both is_jal and is_jalr are set, JALR wins.
- Targets (all arithmetic modulo 2^XLEN, wrap silently):
  - Branch/JAL: pc+imm.
  - JALR: (rs1+imm) with bit0 cleared.
  - redirect_pc = taken ? target : pc+4.
  - link_pc = pc+4.
- mispredict = resolve_taken XOR latched req_pred_taken; valid only while resolve_valid=1.
- Non-pulse outputs hold their last values between resolves.
- BHT:
  - 2-bit saturating counters, index = pc[IDX_W+1:2].
  - Lookup: pred_taken = counter[pred_pc index][1].
  - Update in RESOLVE only, for legal conditional branches: taken increments (saturate at 11), not-taken decrements (saturate at 00). Jumps and illegal ops never update.
  - Lookup and update of the same index in the same cycle returns the pre-update value.
- flush:
  - In EVAL or RESOLVE: return to IDLE next cycle. No resolve_valid, no BHT write.
  - In IDLE with req_valid: the request is not accepted.
  - flush outranks the RESOLVE pulse in the same cycle.
- Reset values:
  - State IDLE.
  - resolve_valid, resolve_taken, mispredict, illegal_br, cmp_brUn = 0.
  - redirect_pc, link_pc = 0.
  - All BHT counters = 01 (weakly not taken).
  - rst mid-operation aborts the op the same way as flush, and also resets the BHT.

Test Plan:
- BEQ, pc=0x100, imm=0x20, Eq=1, pred=0 → resolve_valid at T+2, taken=1, mispredict=1, redirect_pc=0x120, cmp_brUn=0 during EVAL.
- BGEU (111), pc=0x200, Lt=1, pred=0 → cmp_brUn=1 in EVAL, taken=0, mispredict=0, redirect_pc=0x204; BHT[0] stays at 00 after two such ops (saturation).
- JALR, rs1=0x1003, imm=0x4, flags ignored → taken=1, redirect_pc=0x1006, link_pc=pc+4, BHT unchanged.
- Three taken BNEs at pc=0x40 → pred_taken for pred_pc=0x40 reads 0, then 1 after the first resolve, and stays 1; the counter ends at 11.
- funct3=010 → illegal_br=1, taken=0, no BHT write; pc=0xFFFFFFFC, imm=8 taken → redirect_pc=0x4 (wrap).
- Assert flush in EVAL → no resolve_valid, BHT unchanged, req_ready=1 next cycle; rst in RESOLVE → all outputs and the BHT return to reset values.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves RV32I branches/jumps against the shared comparator and owns the 2-bit BHT.
module branch_ctrl #(
  parameter int XLEN = 32,
  parameter int BHT_ENTRIES = 16,
  localparam int IDX_W = $clog2(BHT_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [2:0]      req_funct3,
  input  logic            req_is_jal,
  input  logic            req_is_jalr,
  input  logic            req_pred_taken,
  input  logic            flush,
  output logic            cmp_brUn,
  input  logic            cmp_brEq,
  input  logic            cmp_brLt,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  output logic            resolve_valid,
  output logic            resolve_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] link_pc,
  output logic            illegal_br
);
  typedef enum logic [1:0] {IDLE, EVAL, RESOLVE} state_t;
  state_t state;
  logic [XLEN-1:0] pcQ, immQ, rs1Q, target, pcPlus4;
  logic [2:0] funct3Q;
  logic jalQ, jalrQ, predQ, isJump, illegal, taken, bhtWr;
  logic [1:0] bht [BHT_ENTRIES];
  logic [1:0] bhtCur, bhtNext;
  logic [IDX_W-1:0] updIdx;
  logic unusedPcBits;
  assign unusedPcBits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0], pcQ[XLEN-1:IDX_W+2], pcQ[1:0]};
  assign req_ready = state == IDLE;
  assign cmp_brUn = state == EVAL && funct3Q[1];
  // flush in RESOLVE kills the pulse combinationally, in the same cycle
  assign resolve_valid = state == RESOLVE && !flush;
  assign pred_taken = bht[pred_pc[IDX_W+1:2]][1];
  always_comb begin
    isJump = jalQ | jalrQ;
    illegal = !isJump && funct3Q[2:1] == 2'b01;
    taken = isJump ? 1'b1 : funct3Q[2] ? (cmp_brLt ^ funct3Q[0]) : (!funct3Q[1] && (cmp_brEq ^ funct3Q[0]));
    pcPlus4 = pcQ + XLEN'(4);
    target = jalrQ ? ((rs1Q + immQ) & ~XLEN'(1)) : pcQ + immQ;
    updIdx = pcQ[IDX_W+1:2];
    bhtCur = bht[updIdx];
    bhtNext = resolve_taken ? (bhtCur == 2'b11 ? 2'b11 : bhtCur + 2'b01)
                            : (bhtCur == 2'b00 ? 2'b00 : bhtCur - 2'b01);
    bhtWr = resolve_valid && !isJump && !illegal;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      resolve_taken <= 1'b0;
      mispredict <= 1'b0;
      illegal_br <= 1'b0;
      redirect_pc <= '0;
      link_pc <= '0;
      pcQ <= '0;
      immQ <= '0;
      rs1Q <= '0;
      funct3Q <= '0;
      jalQ <= 1'b0;
      jalrQ <= 1'b0;
      predQ <= 1'b0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else begin
      case (state)
        IDLE: if (req_valid && !flush) begin
          pcQ <= req_pc;
          immQ <= req_imm;
          rs1Q <= req_rs1;
          funct3Q <= req_funct3;
          jalQ <= req_is_jal;
          jalrQ <= req_is_jalr;
          predQ <= req_pred_taken;
          state <= EVAL;
        end
        EVAL: begin
          state <= flush ? IDLE : RESOLVE;
          if (!flush) begin
            resolve_taken <= taken;
            mispredict <= taken ^ predQ;
            illegal_br <= illegal;
            redirect_pc <= taken ? target : pcPlus4;
            link_pc <= pcPlus4;
          end
        end
        RESOLVE: begin
          state <= IDLE;
          if (bhtWr) bht[updIdx] <= bhtNext;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed checks of branch_ctrl resolution, targets, BHT training, flush and reset.
module tb_branch_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [31:0] req_pc = '0, req_imm = '0, req_rs1 = '0, pred_pc = '0;
  logic [2:0] req_funct3 = '0;
  logic req_is_jal = 1'b0, req_is_jalr = 1'b0, req_pred_taken = 1'b0, flush = 1'b0;
  logic cmp_brUn, cmp_brEq = 1'b0, cmp_brLt = 1'b0, pred_taken;
  logic resolve_valid, resolve_taken, mispredict, illegal_br;
  logic [31:0] redirect_pc, link_pc;
  logic evUn, evReady, evRv;
  int checks = 0, errors = 0;

  branch_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_imm(req_imm), .req_rs1(req_rs1), .req_funct3(req_funct3),
    .req_is_jal(req_is_jal), .req_is_jalr(req_is_jalr), .req_pred_taken(req_pred_taken),
    .flush(flush), .cmp_brUn(cmp_brUn), .cmp_brEq(cmp_brEq), .cmp_brLt(cmp_brLt),
    .pred_pc(pred_pc), .pred_taken(pred_taken), .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .link_pc(link_pc), .illegal_br(illegal_br)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op and returns at the falling edge inside RESOLVE; EVAL-cycle samples land in ev*.
  task automatic doOp(input logic [31:0] pc, imm, rs1, input logic [2:0] f3,
                      input logic jal, jalr, pred, eq, lt);
    @(negedge clk);
    req_valid = 1'b1; req_pc = pc; req_imm = imm; req_rs1 = rs1; req_funct3 = f3;
    req_is_jal = jal; req_is_jalr = jalr; req_pred_taken = pred;
    cmp_brEq = eq; cmp_brLt = lt; pred_pc = pc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    evUn = cmp_brUn; evReady = req_ready; evRv = resolve_valid;
    @(negedge clk);
  endtask

  task automatic predAfter(input string tag, input logic exp);
    @(negedge clk);
    chk(tag, pred_taken, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_rv", resolve_valid, 0);
    chk("rst_taken", resolve_taken, 0);
    chk("rst_mis", mispredict, 0);
    chk("rst_ill", illegal_br, 0);
    chk("rst_brun", cmp_brUn, 0);
    chk("rst_redir", redirect_pc, 0);
    chk("rst_link", link_pc, 0);
    chk("rst_pred", pred_taken, 0);
    // three taken BNEs train index 0 from 01 up to 11
    doOp(32'h40, 32'h10, 0, 3'b001, 0, 0, 0, 0, 0);
    chk("bne1_rv", resolve_valid, 1);
    chk("bne1_taken", resolve_taken, 1);
    chk("bne1_mis", mispredict, 1);
    chk("bne1_redir", redirect_pc, 32'h50);
    chk("bne1_pred_preupd", pred_taken, 0);
    predAfter("bne1_pred", 1);
    doOp(32'h40, 32'h10, 0, 3'b001, 0, 0, 1, 0, 0);
    chk("bne2_mis", mispredict, 0);
    predAfter("bne2_pred", 1);
    doOp(32'h40, 32'h10, 0, 3'b001, 0, 0, 1, 0, 0);
    predAfter("bne3_pred", 1);
    doOp(32'h100, 32'h20, 0, 3'b000, 0, 0, 0, 1, 0);
    chk("beq_ev_brun", evUn, 0);
    chk("beq_ev_ready", evReady, 0);
    chk("beq_ev_rv", evRv, 0);
    chk("beq_rv", resolve_valid, 1);
    chk("beq_taken", resolve_taken, 1);
    chk("beq_mis", mispredict, 1);
    chk("beq_redir", redirect_pc, 32'h120);
    chk("beq_link", link_pc, 32'h104);
    chk("beq_ill", illegal_br, 0);
    predAfter("beq_pred_sat11", 1);
    // BGEU with Lt=1 is not taken: 11 -> 10 -> 01 -> 00 -> 00
    for (int k = 0; k < 4; k++) begin
      doOp(32'h200, 32'h40, 0, 3'b111, 0, 0, 0, 0, 1);
      chk("bgeu_ev_brun", evUn, 1);
      chk("bgeu_taken", resolve_taken, 0);
      chk("bgeu_mis", mispredict, 0);
      chk("bgeu_redir", redirect_pc, 32'h204);
      predAfter("bgeu_pred", k == 0);
    end
    doOp(32'h200, 32'h40, 0, 3'b000, 0, 0, 0, 1, 0);
    predAfter("sat00_then_01", 0);
    doOp(32'h200, 32'h40, 0, 3'b000, 0, 0, 0, 1, 0);
    predAfter("sat00_then_10", 1);
    // is_jal and is_jalr both set: JALR target wins, flags ignored
    doOp(32'h308, 32'h4, 32'h1003, 3'b000, 1, 1, 1, 0, 0);
    chk("jalr_rv", resolve_valid, 1);
    chk("jalr_taken", resolve_taken, 1);
    chk("jalr_mis", mispredict, 0);
    chk("jalr_redir", redirect_pc, 32'h1006);
    chk("jalr_link", link_pc, 32'h30c);
    predAfter("jalr_no_bht", 0);
    doOp(32'h100, 32'h20, 0, 3'b010, 0, 0, 0, 1, 1);
    chk("ill_rv", resolve_valid, 1);
    chk("ill_flag", illegal_br, 1);
    chk("ill_taken", resolve_taken, 0);
    chk("ill_redir", redirect_pc, 32'h104);
    predAfter("ill_no_bht", 1);
    chk("ill_hold", illegal_br, 1);
    doOp(32'hfffffffc, 32'h8, 0, 3'b000, 0, 0, 0, 1, 0);
    chk("wrap_redir", redirect_pc, 32'h4);
    chk("wrap_link", link_pc, 32'h0);
    chk("wrap_ill", illegal_br, 0);
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_pc = 32'h80; req_funct3 = 3'b001; req_is_jal = 1'b0;
    req_is_jalr = 1'b0; cmp_brEq = 1'b1; pred_pc = 32'h80;
    @(negedge clk);
    chk("idle_flush_noaccept", req_ready, 1);
    req_valid = 1'b0; flush = 1'b0;
    // not-taken BNE at index 0 (counter 10) would drop the prediction if it wrote the BHT
    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("fl_eval_ready", req_ready, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_eval_ready_next", req_ready, 1);
    chk("fl_eval_rv", resolve_valid, 0);
    chk("fl_eval_redir_hold", redirect_pc, 32'h4);
    @(negedge clk);
    chk("fl_eval_rv_late", resolve_valid, 0);
    chk("fl_eval_bht", pred_taken, 1);
    doOp(32'h80, 32'h0, 0, 3'b001, 0, 0, 0, 1, 0);
    flush = 1'b1;
    #1 chk("fl_res_rv", resolve_valid, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("fl_res_ready", req_ready, 1);
    chk("fl_res_bht", pred_taken, 1);
    doOp(32'h0, 32'h20, 0, 3'b000, 0, 0, 0, 1, 0);
    chk("rst_res_rv_before", resolve_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pred_pc = 32'h40;
    #1;
    chk("rst2_ready", req_ready, 1);
    chk("rst2_rv", resolve_valid, 0);
    chk("rst2_taken", resolve_taken, 0);
    chk("rst2_mis", mispredict, 0);
    chk("rst2_ill", illegal_br, 0);
    chk("rst2_redir", redirect_pc, 0);
    chk("rst2_link", link_pc, 0);
    chk("rst2_bht", pred_taken, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
